// File: rtl/ser5_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ser5_tx
//  Description : 5-bit parallel-to-serial frame transmitter. A frame is a
//                start bit (0), five data bits (MSB- or LSB-first), an
//                optional even-parity bit and a stop bit (1). Back-to-back
//                frames are accepted during the stop bit. All outputs are
//                registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module ser5_tx #(
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic [4:0] din,
    input  logic       load,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [2:0] c_LAST_BIT = 3'd4;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic [4:0] r_shreg;
    logic       r_par;

    logic       w_next_bit;
    logic [4:0] w_shifted;

    // Bit presented next on the line and the shift register after it leaves
    always_comb begin
        w_next_bit = (MSB_FIRST != 0) ? r_shreg[4] : r_shreg[0];
        w_shifted  = (MSB_FIRST != 0) ? {r_shreg[3:0], 1'b0} : {1'b0, r_shreg[4:1]};
    end

    // Frame sequencer; outputs are computed for the state being entered so
    // that they line up with that state's cycle
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_shreg <= 5'd0;
            r_par   <= 1'b0;
            out     <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_STOP: begin
                    if (load) begin
                        // Capture the word; parity is fixed now since din may change
                        r_state <= S_START;
                        r_shreg <= din;
                        r_par   <= ^din;
                        out     <= 1'b0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        out     <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                S_START: begin
                    r_state <= S_DATA;
                    r_cnt   <= 3'd0;
                    out     <= w_next_bit;
                    r_shreg <= w_shifted;
                end
                S_DATA: begin
                    if (r_cnt == c_LAST_BIT) begin
                        r_cnt <= 3'd0;
                        if (PARITY_EN != 0) begin
                            r_state <= S_PARITY;
                            out     <= r_par;
                        end else begin
                            r_state <= S_STOP;
                            out     <= 1'b1;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        out     <= w_next_bit;
                        r_shreg <= w_shifted;
                    end
                end
                S_PARITY: begin
                    r_state <= S_STOP;
                    out     <= 1'b1;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    out     <= 1'b1;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ser5_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ser5_tx
//  Description : Self-checking bench for ser5_tx. Three instances cover
//                parity+MSB-first, no-parity, and LSB-first configurations;
//                expected line waveforms come from a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ser5_tx;

    logic       clock = 1'b0;
    logic       Reset;
    logic       load;
    logic [4:0] din;

    logic out_a, busy_a, ready_a, done_a;
    logic out_b, busy_b, ready_b, done_b;
    logic out_c, busy_c, ready_c, done_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ser5_tx #(.PARITY_EN(1), .MSB_FIRST(1)) u_dut_a (
        .clock(clock), .Reset(Reset), .din(din), .load(load),
        .ready(ready_a), .out(out_a), .busy(busy_a), .done(done_a));

    ser5_tx #(.PARITY_EN(0), .MSB_FIRST(1)) u_dut_b (
        .clock(clock), .Reset(Reset), .din(din), .load(load),
        .ready(ready_b), .out(out_b), .busy(busy_b), .done(done_b));

    ser5_tx #(.PARITY_EN(1), .MSB_FIRST(0)) u_dut_c (
        .clock(clock), .Reset(Reset), .din(din), .load(load),
        .ready(ready_c), .out(out_c), .busy(busy_c), .done(done_c));

    // ---------------- frame-level reference model ----------------
    function automatic int cfg_pe(input int sel);
        return (sel == 1) ? 0 : 1;
    endfunction

    function automatic int cfg_msb(input int sel);
        return (sel == 2) ? 0 : 1;
    endfunction

    function automatic int flen(input int sel);
        return (cfg_pe(sel) != 0) ? 8 : 7;
    endfunction

    // Line level per cycle (bit k = cycle k after acceptance); idle beyond = 1
    function automatic logic [31:0] m_out(input logic [4:0] d, input int sel);
        logic [31:0] v;
        v = '1;
        v[0] = 1'b0;
        for (int i = 0; i < 5; i++)
            v[1 + i] = (cfg_msb(sel) != 0) ? d[4 - i] : d[i];
        if (cfg_pe(sel) != 0)
            v[6] = ($countones(d) % 2) == 1;
        return v;
    endfunction

    function automatic logic [31:0] m_busy(input int sel);
        return (32'd1 << (flen(sel) - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] m_stop(input int sel);
        return 32'd1 << (flen(sel) - 1);
    endfunction

    function automatic logic [31:0] mask(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic sample(input int sel, output logic o, output logic b,
                          output logic r, output logic d);
        case (sel)
            0:       begin o = out_a; b = busy_a; r = ready_a; d = done_a; end
            1:       begin o = out_b; b = busy_b; r = ready_b; d = done_b; end
            default: begin o = out_c; b = busy_c; r = ready_c; d = done_c; end
        endcase
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        load  = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic start(input logic [4:0] d);
        din  = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Record n cycles; din is scrambled every cycle, load pulsed at ld_cycle
    task automatic capture(input int sel, input int n, input int ld_cycle,
                           input logic [4:0] ld_din,
                           output logic [31:0] vo, output logic [31:0] vb,
                           output logic [31:0] vr, output logic [31:0] vd);
        logic o, b, r, d;
        vo = '0; vb = '0; vr = '0; vd = '0;
        for (int k = 0; k < n; k++) begin
            sample(sel, o, b, r, d);
            vo[k] = o; vb[k] = b; vr[k] = r; vd[k] = d;
            if (k == ld_cycle) begin
                din  = ld_din;
                load = 1'b1;
            end else begin
                din  = 5'($urandom);
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic o, b, r, d;
        din = 5'($urandom);
        do_reset();
        for (int s = 0; s < 3; s++) begin
            sample(s, o, b, r, d);
            n_vec++;
            if ({o, r, b, d} !== 4'b1100) begin
                n_err++;
                $display("FAIL reset_state dut%0d: got out/ready/busy/done=%b%b%b%b want 1100", s, o, r, b, d);
            end
        end
    endtask

    task automatic test_basic_frame;
        logic [31:0] vo, vb, vr, vd;
        do_reset();
        start(5'b10110);
        capture(0, 9, -1, 5'd0, vo, vb, vr, vd);
        n_vec++;
        if ((vo & mask(9)) !== 32'h1DA) begin
            n_err++;
            $display("FAIL basic_out: got %b want %b", vo[8:0], 9'h1DA);
        end
        n_vec++;
        if ((vd & mask(9)) !== 32'h080) begin
            n_err++;
            $display("FAIL basic_done: got %b want %b", vd[8:0], 9'h080);
        end
        n_vec++;
        if ((vb & mask(9)) !== 32'h07F) begin
            n_err++;
            $display("FAIL basic_busy: got %b want %b", vb[8:0], 9'h07F);
        end
        n_vec++;
        if ((vr & mask(9)) !== 32'h180) begin
            n_err++;
            $display("FAIL basic_ready: got %b want %b", vr[8:0], 9'h180);
        end
    endtask

    task automatic test_no_parity;
        logic [31:0] vo, vb, vr, vd;
        do_reset();
        start(5'b00000);
        capture(1, 9, -1, 5'd0, vo, vb, vr, vd);
        n_vec++;
        if ((vo & mask(9)) !== 32'h1C0) begin
            n_err++;
            $display("FAIL nopar_out: got %b want %b", vo[8:0], 9'h1C0);
        end
        n_vec++;
        if ((vd & mask(9)) !== 32'h040) begin
            n_err++;
            $display("FAIL nopar_done: got %b want %b", vd[8:0], 9'h040);
        end
    endtask

    task automatic test_lsb_first;
        logic [31:0] vo, vb, vr, vd;
        do_reset();
        start(5'b00011);
        capture(2, 8, -1, 5'd0, vo, vb, vr, vd);
        n_vec++;
        if ((vo & mask(8)) !== 32'h086) begin
            n_err++;
            $display("FAIL lsb_out: got %b want %b", vo[7:0], 8'h86);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vo, vb, vr, vd, eo, ed, eb;
        int L;
        L = flen(0);
        do_reset();
        start(5'b11111);
        capture(0, 2 * L + 1, L - 1, 5'b00001, vo, vb, vr, vd);
        eo = (m_out(5'b11111, 0) & mask(L)) | (m_out(5'b00001, 0) << L);
        ed = m_stop(0) | (m_stop(0) << L);
        eb = m_busy(0) | (m_busy(0) << L);
        n_vec++;
        if ((vo & mask(2 * L + 1)) !== (eo & mask(2 * L + 1))) begin
            n_err++;
            $display("FAIL b2b_out: got %b want %b", vo[16:0], eo[16:0]);
        end
        n_vec++;
        if (vo[6] !== 1'b1 || vo[L + 6] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_parity: got %b,%b want 1,1", vo[6], vo[L + 6]);
        end
        n_vec++;
        if ((vd & mask(2 * L + 1)) !== ed || (vb & mask(2 * L + 1)) !== eb) begin
            n_err++;
            $display("FAIL b2b_done_busy: got done=%b busy=%b want done=%b busy=%b",
                     vd[16:0], vb[16:0], ed[16:0], eb[16:0]);
        end
    endtask

    task automatic test_ignore_load;
        logic [31:0] vo, vb, vr, vd;
        do_reset();
        start(5'b10000);
        capture(0, 11, 3, 5'b01010, vo, vb, vr, vd);
        n_vec++;
        if ((vo & mask(11)) !== (m_out(5'b10000, 0) & mask(11))) begin
            n_err++;
            $display("FAIL ignore_load_out: got %b want %b", vo[10:0], m_out(5'b10000, 0) & mask(11));
        end
        n_vec++;
        if ((vd & mask(11)) !== m_stop(0)) begin
            n_err++;
            $display("FAIL ignore_load_done: got %b want %b", vd[10:0], m_stop(0) & mask(11));
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] vo, vb, vr, vd;
        logic o, b, r, d;
        do_reset();
        start(5'b10101);
        capture(0, 3, -1, 5'd0, vo, vb, vr, vd);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sample(0, o, b, r, d);
        n_vec++;
        if ({o, r, b, d} !== 4'b1100) begin
            n_err++;
            $display("FAIL midreset_state: got out/ready/busy/done=%b%b%b%b want 1100", o, r, b, d);
        end
        capture(0, 10, -1, 5'd0, vo, vb, vr, vd);
        n_vec++;
        if ((vd & mask(10)) !== 32'd0 || (vo & mask(10)) !== mask(10)) begin
            n_err++;
            $display("FAIL midreset_after: got done=%b out=%b want no done, line idle",
                     vd[9:0], vo[9:0]);
        end
        // A load coincident with reset must be dropped
        din   = 5'b00000;
        load  = 1'b1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        load  = 1'b0;
        capture(0, 4, -1, 5'd0, vo, vb, vr, vd);
        n_vec++;
        if ((vo & mask(4)) !== mask(4) || (vb & mask(4)) !== 32'd0) begin
            n_err++;
            $display("FAIL reset_load_priority: got out=%b busy=%b want 1111/0000", vo[3:0], vb[3:0]);
        end
    endtask

    task automatic test_random;
        logic [31:0] vo, vb, vr, vd;
        logic [4:0]  d;
        int          n;
        for (int s = 0; s < 3; s++) begin
            do_reset();
            for (int t = 0; t < 20; t++) begin
                d = 5'($urandom);
                n = flen(s) + 1 + int'($urandom_range(0, 2));
                start(d);
                capture(s, n, -1, 5'd0, vo, vb, vr, vd);
                n_vec++;
                if ((vo & mask(n)) !== (m_out(d, s) & mask(n))) begin
                    n_err++;
                    $display("FAIL rand_out dut%0d din=%b: got %b want %b",
                             s, d, vo & mask(n), m_out(d, s) & mask(n));
                end
                n_vec++;
                if ((vb & mask(n)) !== m_busy(s) || (vd & mask(n)) !== m_stop(s)
                    || (vr & mask(n)) !== (mask(n) & ~m_busy(s))) begin
                    n_err++;
                    $display("FAIL rand_flags dut%0d din=%b: got busy=%b done=%b ready=%b want busy=%b done=%b",
                             s, d, vb & mask(n), vd & mask(n), vr & mask(n), m_busy(s), m_stop(s));
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        load  = 1'b0;
        din   = 5'd0;
        test_reset();
        test_basic_frame();
        test_no_parity();
        test_lsb_first();
        test_back_to_back();
        test_ignore_load();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
